// File: rtl/spram_data_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spram_data_ctrl
// Purpose  : Byte/half/word load-store controller for the cascaded 16K x 32
//            SPRAM data memory, with idle-driven sleep/wake sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module spram_data_ctrl #(
   parameter int IDLE_CYCLES = 256,
   parameter int WAKE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [13:0] mem_addr,
   output logic [31:0] mem_data_in,
   output logic [7:0]  mem_mask_wren,
   output logic        mem_wren,
   output logic        mem_chip_sel,
   output logic        mem_standby,
   output logic        mem_sleep,
   output logic        mem_poweroff,
   input  logic [31:0] mem_data_out
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ISSUE = 3'd1,
      S_RD_CAPT  = 3'd2,
      S_WR_ISSUE = 3'd3,
      S_ERR      = 3'd4,
      S_SLEEP    = 3'd5,
      S_WAKE     = 3'd6
   } state_t;

   localparam int c_IDLE_W = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
   localparam int c_WAKE_W = (WAKE_CYCLES > 2) ? $clog2(WAKE_CYCLES) : 1;
   localparam logic [c_IDLE_W-1:0] c_IDLE_LAST =
      c_IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
   localparam logic [c_WAKE_W-1:0] c_WAKE_LAST =
      c_WAKE_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
   localparam bit c_SLEEP_EN = (IDLE_CYCLES > 0);
   localparam bit c_WAKE_EN  = (WAKE_CYCLES > 0);

   state_t               r_state;
   state_t               w_next_state;
   logic [c_IDLE_W-1:0]  r_idle_cnt;
   logic [c_WAKE_W-1:0]  r_wake_cnt;

   logic                 w_accept;
   logic                 w_misaligned;
   logic [7:0]           w_st_mask;
   logic [31:0]          w_st_data;
   logic [31:0]          w_ld_shift;
   logic [31:0]          w_ld_data;

   logic [1:0]           r_ld_off;
   logic [1:0]           r_ld_size;
   logic                 r_ld_uns;

   logic                 r_rsp_valid;
   logic [31:0]          r_rsp_rdata;
   logic                 r_rsp_err;
   logic [13:0]          r_mem_addr;
   logic [31:0]          r_mem_data_in;
   logic [7:0]           r_mem_mask_wren;
   logic                 r_mem_wren;
   logic                 r_mem_chip_sel;
   logic                 r_mem_standby;
   logic                 r_mem_sleep;
   logic                 r_mem_poweroff;

   logic                 w_unused_addr;

   assign w_unused_addr = ^req_addr[31:16];

   assign req_ready = (r_state == S_IDLE) && !reset;
   assign w_accept  = req_valid && req_ready;

   // Halfwords need even addresses, words (and size 11) need 4-byte alignment.
   always_comb begin
      w_misaligned = 1'b0;
      case (req_size)
         2'b00:   w_misaligned = 1'b0;
         2'b01:   w_misaligned = req_addr[0];
         default: w_misaligned = |req_addr[1:0];
      endcase
   end

   always_comb begin
      w_st_mask = 8'hFF;
      w_st_data = req_wdata;
      case (req_size)
         2'b00: begin
            w_st_mask = 8'b0000_0011 << {req_addr[1:0], 1'b0};
            w_st_data = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_st_mask = 8'h0F << {req_addr[1], 2'b00};
            w_st_data = {2{req_wdata[15:0]}};
         end
         default: begin
            w_st_mask = 8'hFF;
            w_st_data = req_wdata;
         end
      endcase
   end

   assign w_ld_shift = mem_data_out >> {r_ld_off, 3'b000};

   always_comb begin
      w_ld_data = w_ld_shift;
      case (r_ld_size)
         2'b00: w_ld_data = r_ld_uns ? {24'd0, w_ld_shift[7:0]}
                                     : {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
         2'b01: w_ld_data = r_ld_uns ? {16'd0, w_ld_shift[15:0]}
                                     : {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
         default: w_ld_data = w_ld_shift;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_misaligned) begin
                  w_next_state = S_ERR;
               end else if (req_we) begin
                  w_next_state = S_WR_ISSUE;
               end else begin
                  w_next_state = S_RD_ISSUE;
               end
            end else if (!req_valid && c_SLEEP_EN && (r_idle_cnt == c_IDLE_LAST)) begin
               w_next_state = S_SLEEP;
            end
         end
         S_RD_ISSUE: w_next_state = S_RD_CAPT;
         S_RD_CAPT:  w_next_state = S_IDLE;
         S_WR_ISSUE: w_next_state = S_IDLE;
         S_ERR:      w_next_state = S_IDLE;
         S_SLEEP: begin
            if (req_valid) begin
               w_next_state = c_WAKE_EN ? S_WAKE : S_IDLE;
            end
         end
         S_WAKE: begin
            if (r_wake_cnt == c_WAKE_LAST) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Idle counter restarts whenever anything happens; wake counter only runs in WAKE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idle_cnt <= '0;
         r_wake_cnt <= '0;
      end else begin
         if ((r_state == S_IDLE) && !req_valid && (w_next_state == S_IDLE)) begin
            r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
         end else begin
            r_idle_cnt <= '0;
         end
         if (r_state == S_WAKE) begin
            r_wake_cnt <= r_wake_cnt + c_WAKE_W'(1);
         end else begin
            r_wake_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_valid     <= 1'b0;
         r_rsp_rdata     <= '0;
         r_rsp_err       <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_data_in   <= '0;
         r_mem_mask_wren <= '0;
         r_mem_wren      <= 1'b0;
         r_mem_chip_sel  <= 1'b0;
         r_mem_standby   <= 1'b0;
         r_mem_sleep     <= 1'b0;
         r_mem_poweroff  <= 1'b1;
         r_ld_off        <= '0;
         r_ld_size       <= '0;
         r_ld_uns        <= 1'b0;
      end else begin
         r_rsp_valid    <= 1'b0;
         r_mem_standby  <= 1'b0;
         r_mem_poweroff <= 1'b1;
         r_mem_sleep    <= (w_next_state == S_SLEEP);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ld_off  <= req_addr[1:0];
                  r_ld_size <= req_size;
                  r_ld_uns  <= req_unsigned;
                  if (!w_misaligned) begin
                     r_mem_addr     <= req_addr[15:2];
                     r_mem_chip_sel <= 1'b1;
                     r_mem_wren     <= req_we;
                     if (req_we) begin
                        r_mem_data_in   <= w_st_data;
                        r_mem_mask_wren <= w_st_mask;
                     end
                  end
               end
            end
            S_RD_ISSUE: begin
               r_mem_chip_sel <= 1'b0;
               r_mem_wren     <= 1'b0;
            end
            S_WR_ISSUE: begin
               r_mem_chip_sel <= 1'b0;
               r_mem_wren     <= 1'b0;
               r_rsp_valid    <= 1'b1;
               r_rsp_err      <= 1'b0;
               r_rsp_rdata    <= '0;
            end
            S_RD_CAPT: begin
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b0;
               r_rsp_rdata <= w_ld_data;
            end
            S_ERR: begin
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b1;
               r_rsp_rdata <= '0;
            end
            default: begin
               r_mem_chip_sel <= 1'b0;
               r_mem_wren     <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_err       = r_rsp_err;
   assign mem_addr      = r_mem_addr;
   assign mem_data_in   = r_mem_data_in;
   assign mem_mask_wren = r_mem_mask_wren;
   assign mem_wren      = r_mem_wren;
   assign mem_chip_sel  = r_mem_chip_sel;
   assign mem_standby   = r_mem_standby;
   assign mem_sleep     = r_mem_sleep;
   assign mem_poweroff  = r_mem_poweroff;

endmodule
`default_nettype wire

// File: doc/spram_data_ctrl.md
Name: spram_data_ctrl

Overview:
- Load/store controller that sits directly upstream of the cascaded SPRAM data memory (two SB_SPRAM256KA, 16K x 32).
- Converts processor byte/halfword/word requests into word-addressed SPRAM accesses with nibble write masks, aligns and sign/zero-extends load data, and flags misaligned requests.
- Sequences SPRAM sleep after a programmable idle period and wakes it on demand.

Parameters:
- IDLE_CYCLES, 256: consecutive idle cycles before the SPRAM enters sleep. 0 disables sleep.
- WAKE_CYCLES, 4: cycles the SPRAM is held awake and deselected after sleep exit before the first access.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts the request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; bits [15:2] are the word address, upper bits ignored
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle pulse: request completed
- rsp_rdata  out  32  aligned, extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned request, qualified by rsp_valid
- mem_addr  out  14  SPRAM word address
- mem_data_in  out  32  SPRAM write data
- mem_mask_wren  out  8  bit i enables nibble i (bits 4i+3:4i); byte k maps to bits 2k+1:2k
- mem_wren  out  1  SPRAM write enable
- mem_chip_sel  out  1  SPRAM chip select
- mem_standby  out  1  held 0
- mem_sleep  out  1  SPRAM sleep
- mem_poweroff  out  1  active-low power-off, held 1
- mem_data_out  in  32  SPRAM read data, valid the cycle after the SPRAM samples a read

Behaviour:
- Reset values: all mem_* outputs are registered and reset to 0, except mem_poweroff = 1. rsp_valid, rsp_rdata and rsp_err reset to 0. The state machine resets to IDLE with the idle counter at 0.
- req_ready = 1 only in IDLE and not during reset. Otherwise it is 0.
- A request is accepted at edge T when req_valid && req_ready. Inputs are sampled only at that edge.
- States: IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, ERR, SLEEP, WAKE.
- Misaligned request (half with addr[0] = 1, or word with addr[1:0] != 0):
  - IDLE goes to ERR. No SPRAM access is made (chip_sel and wren stay 0).
  - rsp_valid = 1 and rsp_err = 1 in the cycle after T. rsp_rdata = 0.
  - Then return to IDLE.
- Store:
  - At edge T, register mem_addr, mem_data_in, mask, wren = 1 and chip_sel = 1. State becomes WR_ISSUE.
  - The SPRAM writes at T+1. At T+1 deassert chip_sel/wren and pulse rsp_valid. Return to IDLE.
  - mem_data_in replicates the data: byte = {4{b}}, half = {2{h}}, word as-is.
  - Masks: byte k gives 2'b11 << 2k; half at addr[1] gives 4'hF << 4*addr[1]; word gives 8'hFF.
- Load:
  - At edge T, register mem_addr and chip_sel = 1 with wren = 0. State becomes RD_ISSUE.
  - The SPRAM samples at T+1. Deassert chip_sel. State becomes RD_CAPT.
  - At T+2, capture mem_data_out. Shift right by 8*addr[1:0], extend per size/unsigned, drive rsp_rdata and pulse rsp_valid. Return to IDLE.
  - Load-to-response latency is 2 cycles after acceptance.
- rsp_valid is a single-cycle pulse. There is no response backpressure. rsp_rdata holds its value until the next response.
- Back-to-back requests: req_ready re-asserts in the cycle rsp_valid pulses, so a new request can be accepted at the same edge rsp_valid falls.
- Idle counter:
  - Increments each IDLE cycle without req_valid. Clears on any request or non-IDLE state.
  - When it reaches IDLE_CYCLES (nonzero), go to SLEEP with mem_sleep = 1 and chip_sel = 0.
- In SLEEP: req_ready = 0. When req_valid is seen, deassert mem_sleep, go to WAKE and count WAKE_CYCLES. Then go to IDLE.
- The pending request stays on the bus (the requester holds req_valid) and is accepted in IDLE.
- Reset asserted mid-operation forces reset values immediately. The in-flight request is dropped: no rsp_valid and no partial write beyond any edge already taken.

Test Plan:
- Store word 0xDEADBEEF at 0x0010, then load word at 0x0010 → mem_addr = 4, mask 0xFF; rsp_rdata = 0xDEADBEEF two cycles after the load is accepted, rsp_err = 0.
- Store byte 0x80 at 0x0013, then signed byte load at 0x0013 and unsigned byte load at 0x0013 → mask 0xC0, mem_data_in = 0x80808080; signed load returns 0xFFFFFF80, unsigned load returns 0x00000080; word at 0x0010 reads 0x80ADBEEF.
- Halfword store 0x1234 at 0x0012 → mask 0xF0; signed half load at 0x0012 returns 0x00001234.
- Word load at 0x0006 and half load at 0x0001 → rsp_valid and rsp_err = 1 one cycle after acceptance, rsp_rdata = 0, mem_chip_sel never asserted.
- IDLE_CYCLES = 8, WAKE_CYCLES = 4: idle 8 cycles → mem_sleep = 1, req_ready = 0; assert a load → mem_sleep drops, accepted after 4 wake cycles, correct data returned.
- Assert reset in RD_ISSUE → all outputs at reset values immediately, no rsp_valid; after release req_ready = 1 and the memory contents are intact.
